uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive front end of the UART peripheral. It deserializes 8N1 frames from the rx pin into a byte holding register.
- It presents a level "byte ready" flag to the receive control stage. That stage pulse-shapes the flag and issues the receive instruction.
- The CPU consumes the byte by pulsing rd_ack, which releases the holding register for the next frame.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); must be >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clock.
- rd_ack  input  1  one-cycle pulse: CPU has taken rx_data; clears rx_ready, frame_err and overrun.
- rx_data  output  8  last correctly framed byte.
- rx_ready  output  1  level; rx_data holds an unread byte. Feeds the receive control stage's input_sig_rcv.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a frame completed while rx_ready was already 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; bit counter and sample counter are 0.
  - Both synchronizer stages are set to 1.
  - rx_data=8'h00; rx_ready=0; frame_err=0; overrun=0.
  - Reset mid-frame discards the partial byte. No output toggles spuriously on release.
- Input sync:
  - rx passes through a 2-FF synchronizer; rx_s is the second stage.
  - All sampling uses rx_s, so there are 2 cycles of input latency.
- Sample counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - It is cleared on every state entry.
- FSM states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rx_s=0, go to START with counter=0.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - If rx_s=1, treat as a glitch and return to IDLE with no flag change.
    - If rx_s=0, go to DATA with counter=0 and bit index=0.
  - DATA: at count CLKS_PER_BIT-1 (mid bit), shift rx_s into the MSB of the shift register, so the byte is assembled LSB first.
    - Increment the bit index.
    - After DATA_BITS samples, go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1 (good frame), rx_ready=0: load rx_data from the shift register; set rx_ready=1 on the next edge; go to IDLE.
    - rx_s=1 (good frame), rx_ready=1: keep rx_data unchanged; drop the new byte; set overrun=1; go to IDLE.
    - rx_s=0: set frame_err=1; do not load; go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- rx_ready latency: rises one clock after the stop-bit sample edge. It stays high until rd_ack.
- rd_ack:
  - On the edge where rd_ack=1, rx_ready, frame_err and overrun clear to 0.
  - rx_data is held, not cleared.
  - rd_ack with rx_ready=0 is harmless.
- Simultaneous events:
  - rd_ack on the same edge as a good-frame load: the load wins. rx_ready stays 1 with new data, and overrun is not set.
  - rd_ack on the same edge as a framing error: frame_err ends at 1.
- Back-to-back frames: a start bit immediately after the stop sample is accepted, because IDLE is entered at mid stop bit.

Decomposition:
- Shared UART package (uart_pkg):
  - Constants CLKS_PER_BIT_DEFAULT and DATA_BITS.
  - State encoding localparams S_IDLE, S_START, S_DATA, S_STOP, S_BREAK.
- Sub-module sync2: a 2-FF synchronizer with asynchronous active-low reset to 1. It is reused by the transmitter's CTS input.
- The FSM, counters, shift register and flags stay in uart_rx.

Test Plan:
- Frame 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at CLKS_PER_BIT=16 -> rx_ready rises one clock after the stop sample; rx_data=8'hA5; frame_err=0; overrun=0.
- Glitch: rx low for 5 clocks then high (CLKS_PER_BIT=16) -> FSM returns to IDLE; rx_ready, frame_err and overrun all stay 0.
- Frame 8'h3C with stop bit 0, line held low 40 clocks, then high -> frame_err=1; rx_ready=0; rx_data unchanged; FSM in BREAK until the line is high, then frame 8'h11 is received correctly.
- Two frames 8'h01 then 8'h02 with no rd_ack -> rx_data=8'h01; overrun=1. A subsequent rd_ack clears rx_ready and overrun.
- rd_ack pulsed on the exact clock where frame 8'h7E loads -> rx_ready=1; rx_data=8'h7E; overrun=0.
- reset asserted mid-DATA of frame 8'hFF, released, then frame 8'h42 sent -> all outputs 0 during reset; afterwards rx_data=8'h42 and rx_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and the receive state encoding for the UART peripheral.
// Imported by uart_rx and its test bench.
// -----------------------------------------------------------------------------
package uart_pkg;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  // 8N1 framing: data bits per frame, LSB first
  localparam int DATA_BITS = 8;

  // Receive FSM state encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input. Both stages reset to
// 1 so an idle-high serial line reads idle straight out of reset.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset (stages forced to 1)
//   i_d     - asynchronous input
//   o_q     - synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial receive front end: deserializes 8N1 frames from rx into a byte
// holding register and raises a level "byte ready" flag until the CPU
// acknowledges it with rd_ack.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   rx        - serial line, idle high, asynchronous to clock
//   rd_ack    - one-cycle pulse: CPU took rx_data; clears rx_ready/frame_err/overrun
//   rx_data   - last correctly framed byte
//   rx_ready  - level, rx_data holds an unread byte
//   frame_err - sticky, a stop bit was sampled low
//   overrun   - sticky, a frame completed while rx_ready was already set
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 w_rx_s;

  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ready;
  logic                 r_ferr;
  logic                 r_ovr;

  rx_state_t            w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_ready_nxt;
  logic                 w_ferr_nxt;
  logic                 w_ovr_nxt;

  sync2 u_rx_sync (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // State, counters, shift register and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_ferr_nxt  = r_ferr;
    w_ovr_nxt   = r_ovr;

    // Acknowledge first so that a same-edge frame event below overrides it
    if (rd_ack) begin
      w_ready_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
    end else begin
      w_ready_nxt = r_ready;
      w_ferr_nxt  = r_ferr;
      w_ovr_nxt   = r_ovr;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          // High at mid start bit means the falling edge was only a glitch
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          // Shift in at the MSB so the first (LSB) bit ends at bit 0
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + IW'(1);
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            // Returning to IDLE at mid stop bit lets a back-to-back start bit in
            w_state_nxt = S_IDLE;
            if (!r_ready || rd_ack) begin
              w_data_nxt  = r_shift;
              w_ready_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end

      S_BREAK: begin
        // Hold here while the line stays low so a break is not read as frames
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_ready  = r_ready;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic rdy,
                         input logic fe, input logic ov);
    chk({tag, ".data"},  rx_data, d);
    chk({tag, ".ready"}, {7'd0, rx_ready}, {7'd0, rdy});
    chk({tag, ".ferr"},  {7'd0, frame_err}, {7'd0, fe});
    chk({tag, ".ovr"},   {7'd0, overrun}, {7'd0, ov});
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  // Start bit plus data bits, LSB first; stop bit left to the caller
  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    send_bit(1'b1);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clock);
    rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset  = 1'b0;
    rx     = 1'b1;
    rd_ack = 1'b0;
    idle(3);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.state", {5'd0, dut.r_state}, {5'd0, S_IDLE});
    reset = 1'b1;
    idle(4);
    chk_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Frame A5 with exact ready latency around the stop-bit sample
    send_head(8'hA5);
    rx = 1'b1;
    idle(10);
    chk("a5.ready_before", {7'd0, rx_ready}, 8'h00);
    idle(1);
    chk_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(5);
    ack();
    chk_out("a5.ack", 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Glitch: 5 clocks low is rejected at mid start bit
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(20);
    chk_out("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("glitch.state", {5'd0, dut.r_state}, {5'd0, S_IDLE});

    // Frame 3C with low stop bit, line held low 40 clocks
    send_head(8'h3C);
    rx = 1'b0;
    idle(40);
    chk_out("ferr", 8'hA5, 1'b0, 1'b1, 1'b0);
    chk("ferr.state", {5'd0, dut.r_state}, {5'd0, S_BREAK});
    rx = 1'b1;
    idle(4);
    chk("break_exit.state", {5'd0, dut.r_state}, {5'd0, S_IDLE});
    send_frame(8'h11);
    chk_out("after_break", 8'h11, 1'b1, 1'b1, 1'b0);
    ack();
    chk_out("after_break.ack", 8'h11, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Back-to-back frames 01, 02 without acknowledge
    send_frame(8'h01);
    send_frame(8'h02);
    chk_out("overrun", 8'h01, 1'b1, 1'b0, 1'b1);
    ack();
    chk_out("overrun.ack", 8'h01, 1'b0, 1'b0, 1'b0);
    idle(4);

    // rd_ack on the exact load edge of 7E while an earlier byte is unread
    send_frame(8'h55);
    chk_out("pre_7e", 8'h55, 1'b1, 1'b0, 1'b0);
    send_head(8'h7E);
    rx = 1'b1;
    idle(10);
    chk_out("pre_load", 8'h55, 1'b1, 1'b0, 1'b0);
    ack();
    chk_out("ack_on_load", 8'h7E, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Reset in the middle of the data bits of FF
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_reset.state", {5'd0, dut.r_state}, {5'd0, S_IDLE});
    rx = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(4);
    chk_out("reset_release", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h42);
    chk_out("after_reset", 8'h42, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
